// File: rtl/pc_fetch_unit.sv
// Hack CPU program counter and ROM fetch sequencer (IDLE -> FETCH -> ISSUE).
// Latency: rom_req rises 1 cycle after leaving reset or issue, and instr_valid rises 1 cycle after rom_ack.
// Backpressure: ROM stalls hold FETCH indefinitely, the core holds ISSUE until exec_done, and halt parks in IDLE.
module pc_fetch_unit #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              exec_done,
    input  logic              halt,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_VEC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic              r_rom_req;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_rom_req_nxt;
    logic [ADDR_W-1:0] w_rom_addr_nxt;
    logic [DATA_W-1:0] w_instr_nxt;
    logic              w_instr_valid_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = halt ? S_IDLE : S_FETCH;
            S_FETCH: w_state_nxt = rom_ack ? S_ISSUE : S_FETCH;
            S_ISSUE: begin
                if (exec_done) begin
                    w_state_nxt = halt ? S_IDLE : S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; stray rom_ack/exec_done fall through to "hold".
    always_comb begin
        w_pc_nxt          = r_pc;
        w_rom_req_nxt     = r_rom_req;
        w_rom_addr_nxt    = r_rom_addr;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        case (r_state)
            S_IDLE: begin
                if (!halt) begin
                    w_rom_req_nxt  = 1'b1;
                    w_rom_addr_nxt = r_pc;
                end
            end
            S_FETCH: begin
                if (rom_ack) begin
                    w_instr_nxt       = rom_data;
                    w_instr_valid_nxt = 1'b1;
                    w_rom_req_nxt     = 1'b0;
                end
            end
            S_ISSUE: begin
                if (exec_done) begin
                    if (pc_load) begin
                        w_pc_nxt = load_addr;
                    end else if (pc_inc) begin
                        w_pc_nxt = r_pc + ADDR_W'(1);
                    end
                    w_instr_valid_nxt = 1'b0;
                    if (!halt) begin
                        w_rom_req_nxt  = 1'b1;
                        w_rom_addr_nxt = w_pc_nxt;
                    end
                end
            end
            default: begin
                w_rom_req_nxt     = 1'b0;
                w_instr_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= L_RESET_PC;
            r_rom_req     <= 1'b0;
            r_rom_addr    <= L_RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_rom_req     <= w_rom_req_nxt;
            r_rom_addr    <= w_rom_addr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    assign rom_req     = r_rom_req;
    assign rom_addr    = r_rom_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;

endmodule
